// File: rtl/divider_pkg.sv
// Shared constants, FSM state type and operand helper for the iterative divider.
package divider_pkg;

  localparam int DIV_W = 32;
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // Magnitude of a two's-complement operand; passes the value through when unsigned.
  function automatic logic [DIV_W-1:0] op_abs(input logic [DIV_W-1:0] val, input logic is_signed);
    return (is_signed && val[DIV_W-1]) ? (~val + 1'b1) : val;
  endfunction

endpackage

// File: rtl/divider_restore_step.sv
// One combinational restoring-division iteration on a {remainder, quotient} pair.
module divider_restore_step
  import divider_pkg::*;
(
  input  logic [DIV_W-1:0] rem_in,
  input  logic [DIV_W-1:0] quot_in,
  input  logic [DIV_W-1:0] divisor,
  output logic [DIV_W-1:0] rem_out,
  output logic [DIV_W-1:0] quot_out
);

  logic [DIV_W:0] shifted;
  logic [DIV_W:0] trial;

  // The partial remainder is always below the divisor, so the 33-bit shift never loses data.
  assign shifted = {rem_in, quot_in[DIV_W-1]};
  assign trial   = shifted - {1'b0, divisor};

  always_comb begin
    rem_out  = shifted[DIV_W-1:0];
    quot_out = {quot_in[DIV_W-2:0], 1'b0};
    if (!trial[DIV_W]) begin
      rem_out  = trial[DIV_W-1:0];
      quot_out = {quot_in[DIV_W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/divider.sv
// Iterative 32-bit radix-2 restoring divider (DIV/DIVU) with cancel and fixed latency.
//
// state | meaning
// IDLE  | waiting for div_start; operands and signs latched on accept
// CALC  | 32 restoring steps, one per cycle, counter 0..31
// FIX   | apply quotient/remainder signs, register results
// DONE  | div_done pulse, then back to IDLE
module divider
  import divider_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             div_start,
  input  logic             div_signed,
  input  logic             div_cancel,
  input  logic [DIV_W-1:0] div_a,
  input  logic [DIV_W-1:0] div_b,
  output logic             div_busy,
  output logic             div_done,
  output logic [DIV_W-1:0] div_quot,
  output logic [DIV_W-1:0] div_rem
);

  div_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [DIV_W-1:0] p_rem;
  logic [DIV_W-1:0] p_quot;
  logic [DIV_W-1:0] dvsr;
  logic             quot_neg;
  logic             rem_neg;
  logic [DIV_W-1:0] step_rem;
  logic [DIV_W-1:0] step_quot;

  divider_restore_step u_step (
    .rem_in   (p_rem),
    .quot_in  (p_quot),
    .divisor  (dvsr),
    .rem_out  (step_rem),
    .quot_out (step_quot)
  );

  assign div_done = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      p_rem    <= '0;
      p_quot   <= '0;
      dvsr     <= '0;
      quot_neg <= 1'b0;
      rem_neg  <= 1'b0;
      div_busy <= 1'b0;
      div_quot <= '0;
      div_rem  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (div_start) begin
            p_rem    <= '0;
            p_quot   <= op_abs(div_a, div_signed);
            dvsr     <= op_abs(div_b, div_signed);
            quot_neg <= div_signed & (div_a[DIV_W-1] ^ div_b[DIV_W-1]);
            rem_neg  <= div_signed & div_a[DIV_W-1];
            cnt      <= '0;
            div_busy <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          if (div_cancel) begin
            div_busy <= 1'b0;
            state    <= IDLE;
          end else begin
            p_rem  <= step_rem;
            p_quot <= step_quot;
            if (cnt == CNT_W'(DIV_W - 1)) begin
              state <= FIX;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        FIX: begin
          if (div_cancel) begin
            div_busy <= 1'b0;
            state    <= IDLE;
          end else begin
            div_quot <= quot_neg ? (~p_quot + 1'b1) : p_quot;
            div_rem  <= rem_neg  ? (~p_rem + 1'b1)  : p_rem;
            state    <= DONE;
          end
        end
        DONE: begin
          div_busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          div_busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: cycle model compared every cycle plus directed literal vectors.
module tb_divider;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        div_start = 1'b0;
  logic        div_signed = 1'b0;
  logic        div_cancel = 1'b0;
  logic [31:0] div_a = '0;
  logic [31:0] div_b = '0;
  logic        div_busy;
  logic        div_done;
  logic [31:0] div_quot;
  logic [31:0] div_rem;

  int checks = 0;
  int errors = 0;

  divider dut (
    .clk        (clk),
    .reset      (reset),
    .div_start  (div_start),
    .div_signed (div_signed),
    .div_cancel (div_cancel),
    .div_a      (div_a),
    .div_b      (div_b),
    .div_busy   (div_busy),
    .div_done   (div_done),
    .div_quot   (div_quot),
    .div_rem    (div_rem)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result from plain arithmetic: magnitudes, truncating divide, then sign rules.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] ua, ub, q, r;
    ua = (s && a[31]) ? -a : a;
    ub = (s && b[31]) ? -b : b;
    if (ub == 0) begin
      q = 32'hFFFF_FFFF;
      r = ua;
    end else begin
      q = ua / ub;
      r = ua % ub;
    end
    if (s && (a[31] ^ b[31])) q = -q;
    if (s && a[31]) r = -r;
    return {q, r};
  endfunction

  // Cycle model: an accepted op is busy for 34 samples, done on the last, results appear then.
  bit          m_valid = 0;
  bit          m_active = 0;
  int          m_age = 0;
  logic [31:0] m_quot = '0, m_rem = '0;
  logic [63:0] m_res = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1;
      m_active = 0;
      m_age = 0;
      m_quot = '0;
      m_rem = '0;
    end else if (!m_active) begin
      if (div_start) begin
        m_active = 1;
        m_age = 0;
        m_res = ref_div(div_a, div_b, div_signed);
      end
    end else if (m_age == 33) begin
      m_active = 0;
    end else if (div_cancel) begin
      m_active = 0;
    end else begin
      m_age++;
      if (m_age == 33) begin
        m_quot = m_res[63:32];
        m_rem  = m_res[31:0];
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("busy", {31'd0, div_busy}, {31'd0, m_active});
      check("done", {31'd0, div_done}, {31'd0, (m_active && m_age == 33)});
      check("quot", div_quot, m_quot);
      check("rem",  div_rem,  m_rem);
    end
  end

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input bit lit, input logic [31:0] eq, input logic [31:0] er);
    int busy_cnt;
    int lat;
    bit seen;
    @(posedge clk); #2;
    div_a = a; div_b = b; div_signed = s; div_start = 1'b1;
    @(posedge clk); #2;
    div_start = 1'b0;
    busy_cnt = 0; lat = 0; seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (div_busy) busy_cnt++;
      if (div_done) seen = 1;
    end
    check("done_seen", {31'd0, seen}, 32'd1);
    check("latency", lat, 32'd34);
    check("busy_cycles", busy_cnt, 32'd34);
    if (lit) begin
      check("lit_quot", div_quot, eq);
      check("lit_rem",  div_rem,  er);
    end
  endtask

  initial begin
    logic [63:0] r;
    logic [31:0] ra, rb, keep_q, keep_r;
    logic        rs;
    int          dones;

    r = ref_div(32'd100, 32'd7, 1'b0);
    check("model_100_7", r[63:32] ^ r[31:0], 32'd14 ^ 32'd2);
    r = ref_div(32'hFFFF_FFF9, 32'd2, 1'b1);
    check("model_m7_2_q", r[63:32], 32'hFFFF_FFFD);
    check("model_m7_2_r", r[31:0], 32'hFFFF_FFFF);

    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'd0, div_busy}, 32'd0);
    check("rst_done", {31'd0, div_done}, 32'd0);
    check("rst_quot", div_quot, 32'd0);
    check("rst_rem",  div_rem,  32'd0);

    run_op(32'd100,       32'd7,        1'b0, 1, 32'd14,        32'd2);
    run_op(32'hFFFF_FFF9, 32'd2,        1'b1, 1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_op(32'd7,         32'hFFFF_FFFE, 1'b1, 1, 32'hFFFF_FFFD, 32'd1);
    run_op(32'hFFFF_FFF9, 32'd2,        1'b0, 1, 32'h7FFF_FFFC, 32'd1);
    run_op(32'd7,         32'hFFFF_FFFE, 1'b0, 1, 32'd0,         32'd7);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1, 32'h8000_0000, 32'd0);
    run_op(32'h1234_5678, 32'd0,        1'b0, 1, 32'hFFFF_FFFF, 32'h1234_5678);
    run_op(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 1, 32'd14,        32'hFFFF_FFFE);
    run_op(32'd0,         32'd5,        1'b1, 1, 32'd0,         32'd0);

    // Cancel ten cycles into CALC: previous results must survive.
    keep_q = div_quot; keep_r = div_rem;
    @(posedge clk); #2;
    div_a = 32'd1000; div_b = 32'd3; div_signed = 1'b0; div_start = 1'b1;
    @(posedge clk); #2;
    div_start = 1'b0;
    repeat (10) @(posedge clk);
    #2 div_cancel = 1'b1;
    @(posedge clk); #2;
    div_cancel = 1'b0;
    @(negedge clk);
    check("cancel_busy", {31'd0, div_busy}, 32'd0);
    check("cancel_quot", div_quot, keep_q);
    check("cancel_rem",  div_rem,  keep_r);
    run_op(32'd1000, 32'd3, 1'b0, 1, 32'd333, 32'd1);

    // Reset in the middle of CALC.
    @(posedge clk); #2;
    div_a = 32'd55; div_b = 32'd4; div_start = 1'b1;
    @(posedge clk); #2;
    div_start = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_busy", {31'd0, div_busy}, 32'd0);
    check("midrst_done", {31'd0, div_done}, 32'd0);
    check("midrst_quot", div_quot, 32'd0);
    check("midrst_rem",  div_rem,  32'd0);

    // Start held through the whole operation yields a single done.
    @(posedge clk); #2;
    div_a = 32'd81; div_b = 32'd9; div_signed = 1'b0; div_start = 1'b1;
    dones = 0;
    for (int i = 0; i < 100 && dones == 0; i++) begin
      @(negedge clk);
      if (div_done) dones++;
    end
    @(posedge clk); #2;
    div_start = 1'b0;
    check("held_quot", div_quot, 32'd9);
    check("held_rem",  div_rem,  32'd0);
    repeat (40) begin
      @(negedge clk);
      if (div_done) dones++;
    end
    check("held_done_count", dones, 32'd1);

    // Random back-to-back operations, checked by the cycle model.
    for (int n = 0; n < 1000; n++) begin
      ra = $urandom;
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: rb = $urandom_range(0, 15);
        1: rb = -$urandom_range(1, 15);
        default: rb = $urandom;
      endcase
      if (rs && rb == 0) rb = 32'd1;
      run_op(ra, rb, rs, 0, 32'd0, 32'd0);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
